philv_exec_control: RTL and testbench

Combined control and execute block for the Philosophy-V core: a multicycle main-control FSM, an ALU-function decoder, and an N-bit integer ALU. It sits between the instruction-fetch register and the register file/ALU operand mux. It sequences PC update, ALU source selection and register-file write for RV32I register-register (OP) and register-immediate (OP-IMM) instructions.

---
 rtl/philv_exec_control.sv | 162 ++++++++++++++++
 tb/tb_philv_exec_control.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/philv_exec_control.sv
// Philosophy-V multicycle control + execute: main FSM, ALU-function decoder and N-bit ALU.
// Handles RV32I OP and OP-IMM instructions; any other opcode retires as a two-cycle NOP.
module philv_exec_control #(
    parameter int unsigned N = 32
) (
    input  logic         clk,
    input  logic         rstb,
    input  logic [31:0]  instr,
    input  logic [N-1:0] alu_x,
    input  logic [N-1:0] alu_y,
    output logic         pc_write,
    output logic [1:0]   alu_src_b,
    output logic         reg_file_write,
    output logic [3:0]   alu_funct,
    output logic [N-1:0] alu_z,
    output logic         alu_zero,
    output logic [1:0]   state
);

    localparam int unsigned SHW = $clog2(N);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

    localparam logic [3:0] F_ADD  = 4'b0000;
    localparam logic [3:0] F_SUB  = 4'b1000;
    localparam logic [3:0] F_SLL  = 4'b0001;
    localparam logic [3:0] F_SLT  = 4'b0010;
    localparam logic [3:0] F_SLTU = 4'b0011;
    localparam logic [3:0] F_XOR  = 4'b0100;
    localparam logic [3:0] F_SRL  = 4'b0101;
    localparam logic [3:0] F_SRA  = 4'b1101;
    localparam logic [3:0] F_OR   = 4'b0110;
    localparam logic [3:0] F_AND  = 4'b0111;

    localparam logic [1:0] SRC_RS2  = 2'b00;
    localparam logic [1:0] SRC_FOUR = 2'b01;
    localparam logic [1:0] SRC_IMM  = 2'b10;

    typedef enum logic [1:0] {
        S_FETCH     = 2'b00,
        S_DECODE    = 2'b01,
        S_EXECUTE   = 2'b10,
        S_WRITEBACK = 2'b11
    } state_t;

    state_t      state_q, state_n;
    logic [31:0] ir_q, ir_n;
    logic        run_q;
    logic        pc_write_n;
    logic        reg_file_write_n;
    logic [1:0]  alu_src_b_n;
    logic [3:0]  alu_funct_n;

    // ALU function from opcode/funct3/funct7 of a latched instruction
    function automatic logic [3:0] decode_funct(input logic [31:0] i);
        logic [6:0] opc;
        logic [2:0] f3;
        logic [6:0] f7;
        logic [3:0] f;
        opc = i[6:0];
        f3  = i[14:12];
        f7  = i[31:25];
        f   = F_ADD;
        if (opc == OPC_OP) begin
            if (f7 == 7'b0000000)
                f = {1'b0, f3};
            else if (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101))
                f = {1'b1, f3};
        end else if (opc == OPC_OP_IMM) begin
            if (f3 == 3'b001 || f3 == 3'b101)
                f = {f7[5], f3};
            else
                f = {1'b0, f3};
        end
        return f;
    endfunction

    // Next state plus the Moore outputs that belong to that next state
    always_comb begin
        state_n          = state_q;
        ir_n             = ir_q;
        pc_write_n       = 1'b0;
        reg_file_write_n = 1'b0;
        alu_src_b_n      = SRC_RS2;
        alu_funct_n      = F_ADD;

        unique case (state_q)
            S_FETCH:     state_n = run_q ? S_DECODE : S_FETCH;
            S_DECODE: begin
                ir_n    = instr;
                state_n = (instr[6:0] == OPC_OP || instr[6:0] == OPC_OP_IMM) ? S_EXECUTE : S_FETCH;
            end
            S_EXECUTE:   state_n = S_WRITEBACK;
            S_WRITEBACK: state_n = S_FETCH;
            default:     state_n = S_FETCH;
        endcase

        unique case (state_n)
            S_FETCH: begin
                pc_write_n  = 1'b1;
                alu_src_b_n = SRC_FOUR;
            end
            S_EXECUTE, S_WRITEBACK: begin
                reg_file_write_n = (state_n == S_WRITEBACK);
                alu_src_b_n      = (ir_n[6:0] == OPC_OP_IMM) ? SRC_IMM : SRC_RS2;
                alu_funct_n      = decode_funct(ir_n);
            end
            default: ;
        endcase
    end

    // run_q holds FETCH for one extra cycle right after reset release
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q        <= S_FETCH;
            ir_q           <= '0;
            run_q          <= 1'b0;
            pc_write       <= 1'b0;
            reg_file_write <= 1'b0;
            alu_src_b      <= SRC_RS2;
            alu_funct      <= F_ADD;
        end else begin
            state_q        <= state_n;
            ir_q           <= ir_n;
            run_q          <= 1'b1;
            pc_write       <= pc_write_n;
            reg_file_write <= reg_file_write_n;
            alu_src_b      <= alu_src_b_n;
            alu_funct      <= alu_funct_n;
        end
    end

    assign state = state_q;

    // Register/immediate fields are consumed elsewhere in the datapath
    logic unused_ir_fields;
    assign unused_ir_fields = ^{ir_q[24:15], ir_q[11:7]};

    logic [SHW-1:0] shamt;
    assign shamt = alu_y[SHW-1:0];

    always_comb begin
        alu_z = '0;
        unique case (alu_funct)
            F_ADD:   alu_z = alu_x + alu_y;
            F_SUB:   alu_z = alu_x - alu_y;
            F_SLL:   alu_z = alu_x << shamt;
            F_SLT:   alu_z = N'($signed(alu_x) < $signed(alu_y));
            F_SLTU:  alu_z = N'(alu_x < alu_y);
            F_XOR:   alu_z = alu_x ^ alu_y;
            F_SRL:   alu_z = alu_x >> shamt;
            F_SRA:   alu_z = N'($signed(alu_x) >>> shamt);
            F_OR:    alu_z = alu_x | alu_y;
            F_AND:   alu_z = alu_x & alu_y;
            default: alu_z = '0;
        endcase
    end

    assign alu_zero = (alu_z == '0);

endmodule

// File: tb/tb_philv_exec_control.sv
// Directed bench for philv_exec_control: reset, FSM sequencing, decoder and ALU results.
module tb_philv_exec_control;

    logic        clk = 1'b0;
    logic        rstb;
    logic [31:0] instr;
    logic [31:0] alu_x;
    logic [31:0] alu_y;
    logic        pc_write;
    logic [1:0]  alu_src_b;
    logic        reg_file_write;
    logic [3:0]  alu_funct;
    logic [31:0] alu_z;
    logic        alu_zero;
    logic [1:0]  state;

    int n_tests = 0;
    int n_fail  = 0;

    philv_exec_control #(.N(32)) dut (
        .clk            (clk),
        .rstb           (rstb),
        .instr          (instr),
        .alu_x          (alu_x),
        .alu_y          (alu_y),
        .pc_write       (pc_write),
        .alu_src_b      (alu_src_b),
        .reg_file_write (reg_file_write),
        .alu_funct      (alu_funct),
        .alu_z          (alu_z),
        .alu_zero       (alu_zero),
        .state          (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full supported instruction starting in FETCH; returns in the next FETCH
    task automatic run_instr(input string name, input logic [31:0] i, input logic [3:0] ef,
                             input logic [1:0] es, input logic [31:0] x, input logic [31:0] y,
                             input logic [31:0] ez);
        instr = i;
        tick();
        check({name, " decode state"}, 32'(state), 32'd1);
        check({name, " decode funct"}, 32'(alu_funct), 32'd0);
        tick();
        instr = 32'h0000_0073;
        alu_x = x;
        alu_y = y;
        #1;
        check({name, " exec state"}, 32'(state), 32'd2);
        check({name, " exec funct"}, 32'(alu_funct), 32'(ef));
        check({name, " exec src"}, 32'(alu_src_b), 32'(es));
        check({name, " exec rfw"}, 32'(reg_file_write), 32'd0);
        check({name, " alu_z"}, alu_z, ez);
        check({name, " alu_zero"}, 32'(alu_zero), 32'(ez == 32'd0));
        tick();
        check({name, " wb state"}, 32'(state), 32'd3);
        check({name, " wb rfw"}, 32'(reg_file_write), 32'd1);
        check({name, " wb funct"}, 32'(alu_funct), 32'(ef));
        check({name, " wb src"}, 32'(alu_src_b), 32'(es));
        tick();
        check({name, " fetch state"}, 32'(state), 32'd0);
        check({name, " fetch pcw"}, 32'(pc_write), 32'd1);
        check({name, " fetch rfw"}, 32'(reg_file_write), 32'd0);
        check({name, " fetch src"}, 32'(alu_src_b), 32'd1);
    endtask

    initial begin
        rstb  = 1'b0;
        instr = 32'h0020_81B3;
        alu_x = 32'd0;
        alu_y = 32'd0;
        repeat (3) tick();
        check("rst state", 32'(state), 32'd0);
        check("rst pcw", 32'(pc_write), 32'd0);
        check("rst rfw", 32'(reg_file_write), 32'd0);
        check("rst src", 32'(alu_src_b), 32'd0);
        check("rst funct", 32'(alu_funct), 32'd0);

        rstb = 1'b1;
        tick();
        check("post-rst state", 32'(state), 32'd0);
        check("post-rst pcw", 32'(pc_write), 32'd1);
        check("post-rst src", 32'(alu_src_b), 32'd1);
        tick();
        check("post-rst decode", 32'(state), 32'd1);
        check("post-rst pcw low", 32'(pc_write), 32'd0);

        // First ADD is already in DECODE
        tick();
        instr = 32'h4020_81B3;
        alu_x = 32'd5;
        alu_y = 32'd7;
        #1;
        check("add exec state", 32'(state), 32'd2);
        check("add exec funct", 32'(alu_funct), 32'h0);
        check("add exec src", 32'(alu_src_b), 32'd0);
        check("add alu_z", alu_z, 32'd12);
        check("add exec rfw", 32'(reg_file_write), 32'd0);
        tick();
        check("add wb state", 32'(state), 32'd3);
        check("add wb rfw", 32'(reg_file_write), 32'd1);
        check("add wb funct", 32'(alu_funct), 32'h0);
        tick();
        check("add fetch state", 32'(state), 32'd0);
        check("add fetch pcw", 32'(pc_write), 32'd1);
        check("add fetch rfw", 32'(reg_file_write), 32'd0);

        run_instr("sub wrap", 32'h4020_81B3, 4'b1000, 2'b00, 32'd0, 32'd1, 32'hFFFF_FFFF);
        run_instr("sub zero", 32'h4020_81B3, 4'b1000, 2'b00, 32'd9, 32'd9, 32'd0);
        run_instr("sra", 32'h4020_D1B3, 4'b1101, 2'b00, 32'h8000_0000, 32'd4, 32'hF800_0000);
        run_instr("srl", 32'h0020_D1B3, 4'b0101, 2'b00, 32'h8000_0000, 32'd4, 32'h0800_0000);
        run_instr("slt", 32'h0020_A1B3, 4'b0010, 2'b00, 32'hFFFF_FFFF, 32'd1, 32'd1);
        run_instr("sltu", 32'h0020_B1B3, 4'b0011, 2'b00, 32'hFFFF_FFFF, 32'd1, 32'd0);
        run_instr("sll", 32'h0020_91B3, 4'b0001, 2'b00, 32'd1, 32'd31, 32'h8000_0000);
        run_instr("xor", 32'h0020_C1B3, 4'b0100, 2'b00, 32'hF0F0_1234, 32'h0FF0_1230, 32'hFF00_0004);
        run_instr("or", 32'h0020_E1B3, 4'b0110, 2'b00, 32'hF000_000F, 32'h0F00_00F0, 32'hFF00_00FF);
        run_instr("and", 32'h0020_F1B3, 4'b0111, 2'b00, 32'hF0F0_FFFF, 32'hFF00_00F0, 32'hF000_00F0);
        run_instr("op bad f7", 32'h0220_81B3, 4'b0000, 2'b00, 32'd3, 32'd4, 32'd7);
        run_instr("addi", 32'h0050_8093, 4'b0000, 2'b10, 32'd3, 32'd5, 32'd8);
        run_instr("addi f7b5", 32'h4050_8093, 4'b0000, 2'b10, 32'd10, 32'd6, 32'd16);
        run_instr("srai", 32'h4040_D093, 4'b1101, 2'b10, 32'h8000_0000, 32'd4, 32'hF800_0000);

        // Unsupported opcode retires through FETCH->DECODE->FETCH
        instr = 32'h0000_0073;
        tick();
        check("nop decode state", 32'(state), 32'd1);
        check("nop decode rfw", 32'(reg_file_write), 32'd0);
        tick();
        check("nop fetch state", 32'(state), 32'd0);
        check("nop fetch rfw", 32'(reg_file_write), 32'd0);
        check("nop fetch pcw", 32'(pc_write), 32'd1);

        // Reset asserted in the middle of EXECUTE
        instr = 32'h0020_81B3;
        tick();
        tick();
        check("mid exec state", 32'(state), 32'd2);
        #2;
        rstb = 1'b0;
        #1;
        check("mid rst state", 32'(state), 32'd0);
        check("mid rst rfw", 32'(reg_file_write), 32'd0);
        check("mid rst pcw", 32'(pc_write), 32'd0);
        tick();
        check("mid rst hold rfw", 32'(reg_file_write), 32'd0);
        check("mid rst hold state", 32'(state), 32'd0);
        rstb = 1'b1;
        tick();
        check("re-rst pcw", 32'(pc_write), 32'd1);
        tick();
        check("re-rst decode", 32'(state), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
